// File: rtl/modulo_unfold.sv
// modulo_unfold: unwraps modulo-folded fixed-point samples by first-order
// difference unfolding (difference, fold into [-LAMBDA, LAMBDA), accumulate).
//
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   clear        : synchronous frame restart (drops in-flight samples)
//   in_valid/in_ready/in_data    : folded sample input y[n]
//   out_valid/out_ready/out_data : unfolded sample output x[n]
//   out_sat      : current out_data was clamped
//   sat_sticky   : a clamp occurred since last reset/clear
//
// Optional macro UNFOLD_SAT_EN: clamp out_data to the TOTAL_BITS signed range
// and report out_sat/sat_sticky. Without it out_data wraps and both flags are 0.
module modulo_unfold #(
  parameter int unsigned TOTAL_BITS      = 16,
  parameter int unsigned FRACTIONAL_BITS = 10,
  parameter int unsigned LAMBDA          = 1024,
  parameter int unsigned ACC_BITS        = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out_data,
  output logic                  out_sat,
  output logic                  sat_sticky
);

  localparam int unsigned DW = TOTAL_BITS + 2;
  localparam logic signed [DW-1:0] LAM_C     = DW'(LAMBDA);
  localparam logic signed [DW-1:0] NEG_LAM_C = -LAM_C;
  localparam logic signed [DW-1:0] TWO_LAM_C = DW'(2 * LAMBDA);

  // Elaboration-time parameter sanity check.
  if ((ACC_BITS <= TOTAL_BITS) || (FRACTIONAL_BITS > TOTAL_BITS) || (LAMBDA < 32'd1) ||
      (LAMBDA > (32'd1 << (TOTAL_BITS - 2)))) begin : g_bad_params
    $error("modulo_unfold: illegal parameter set");
  end

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [TOTAL_BITS-1:0]    prev_q, prev_d;
  logic signed [DW-1:0]     d1_q, d1_d;
  logic                     v1_q, v1_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic                     v2_q, v2_d;
  logic                     out_valid_q, out_valid_d;
  logic [TOTAL_BITS-1:0]    out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     sat_sticky_q, sat_sticky_d;

  logic                     en_c;
  logic                     accept_c;
  logic signed [DW-1:0]     y_ext_c, prev_ext_c, diff_c, fold_c;
  logic [TOTAL_BITS-1:0]    conv_data_c;
  logic                     conv_sat_c;

  // Whole pipeline advances only when the output register is free.
  assign en_c     = !out_valid_q || out_ready;
  assign in_ready = en_c && !clear && rst_n;
  assign accept_c = in_valid && in_ready;

  // Stage-1 difference with fold; the first sample of a frame passes unfolded.
  assign y_ext_c    = DW'($signed(in_data));
  assign prev_ext_c = DW'($signed(prev_q));
  assign diff_c     = y_ext_c - prev_ext_c;

  always_comb begin
    fold_c = diff_c;
    if (state_q == ST_FIRST) begin
      fold_c = y_ext_c;
    end else if (diff_c >= LAM_C) begin
      fold_c = diff_c - TWO_LAM_C;
    end else if (diff_c < NEG_LAM_C) begin
      fold_c = diff_c + TWO_LAM_C;
    end
  end

  // Accumulator to output-width conversion; acc itself is never clamped.
`ifdef UNFOLD_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX_C =
    {{(ACC_BITS - TOTAL_BITS + 1){1'b0}}, {(TOTAL_BITS - 1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN_C =
    {{(ACC_BITS - TOTAL_BITS + 1){1'b1}}, {(TOTAL_BITS - 1){1'b0}}};

  always_comb begin
    conv_data_c = acc_q[TOTAL_BITS-1:0];
    conv_sat_c  = 1'b0;
    if (acc_q > SAT_MAX_C) begin
      conv_data_c = TOTAL_BITS'(SAT_MAX_C);
      conv_sat_c  = 1'b1;
    end else if (acc_q < SAT_MIN_C) begin
      conv_data_c = TOTAL_BITS'(SAT_MIN_C);
      conv_sat_c  = 1'b1;
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc_q[ACC_BITS-1:TOTAL_BITS];
  assign conv_data_c   = acc_q[TOTAL_BITS-1:0];
  assign conv_sat_c    = 1'b0;
`endif

  // Next-state: clear wins over everything, otherwise advance on en_c.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    d1_d         = d1_q;
    v1_d         = v1_q;
    acc_d        = acc_q;
    v2_d         = v2_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;
    sat_sticky_d = sat_sticky_q;

    if (clear) begin
      state_d      = ST_FIRST;
      prev_d       = '0;
      v1_d         = 1'b0;
      acc_d        = '0;
      v2_d         = 1'b0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_sat_d    = 1'b0;
      sat_sticky_d = 1'b0;
    end else if (en_c) begin
      v1_d = accept_c;
      if (accept_c) begin
        d1_d    = fold_c;
        prev_d  = in_data;
        state_d = ST_RUN;
      end
      v2_d = v1_q;
      if (v1_q) begin
        acc_d = acc_q + ACC_BITS'(d1_q);
      end
      out_valid_d = v2_q;
      if (v2_q) begin
        out_data_d = conv_data_c;
        out_sat_d  = conv_sat_c;
        if (conv_sat_c) begin
          sat_sticky_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FIRST;
      prev_q       <= '0;
      d1_q         <= '0;
      v1_q         <= 1'b0;
      acc_q        <= '0;
      v2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      d1_q         <= d1_d;
      v1_q         <= v1_d;
      acc_q        <= acc_d;
      v2_q         <= v2_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_modulo_unfold.sv
`timescale 1ns/1ps
module tb_modulo_unfold;

`ifdef UNFOLD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        sat_sticky;

  modulo_unfold #(
    .TOTAL_BITS     (16),
    .FRACTIONAL_BITS(10),
    .LAMBDA         (1024),
    .ACC_BITS       (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_sticky(sat_sticky)
  );

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          exp_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  logic [15:0] held;
  bit   hold_armed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed) check("hold_out_data", $signed(out_data), $signed(held));
      if (out_valid && !out_ready) begin
        check("hold_in_ready", 32'(in_ready), 0);
        hold_armed = 1'b1;
        held = out_data;
      end else begin
        hold_armed = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected no output", $signed(out_data));
        end else begin
          mon_e = sb.pop_front();
          pops++;
          check("out_data", $signed(out_data), $signed(mon_e.data));
          check("out_sat", 32'(out_sat), 32'(mon_e.sat));
          if (mon_e.chk_lat) check("latency", cyc, mon_e.exp_cyc);
        end
      end
    end
  end

  task automatic send(input logic signed [15:0] y, input logic signed [15:0] exp_d,
                      input logic exp_sat, input bit lat);
    exp_t e;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = y;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      e.data    = exp_d;
      e.sat     = exp_sat;
      e.exp_cyc = cyc + 3;
      e.chk_lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outputs missing expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Saturation ramp: y[n] folds a 1000-LSB/sample ramp into [-1024, 1024).
  task automatic ramp(input int last);
    logic signed [15:0] ed;
    logic es;
    int v;
    int y;
    for (int n = 0; n <= last; n++) begin
      v = 1000 * n;
      y = ((v + 1024) % 2048) - 1024;
      if (SAT_EN && v > 32767) begin
        ed = 16'sd32767;
        es = 1'b1;
      end else begin
        ed = 16'(v);
        es = 1'b0;
      end
      send(16'(y), ed, es, 1'b0);
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    int wait_n;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    check("rst_sat_sticky", 32'(sat_sticky), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic unfold, back-to-back with latency checks.
    send(16'sd0, 16'sd0, 1'b0, 1'b1);
    send(16'sd900, 16'sd900, 1'b0, 1'b1);
    send(-16'sd900, 16'sd1148, 1'b0, 1'b1);
    send(-16'sd700, 16'sd1348, 1'b0, 1'b1);
    idle();
    drain();
    restart();

    // Negative fold.
    send(16'sd0, 16'sd0, 1'b0, 1'b1);
    send(-16'sd900, -16'sd900, 1'b0, 1'b1);
    send(16'sd900, -16'sd1148, 1'b0, 1'b1);
    idle();
    drain();
    restart();

    // Backpressure: 4-cycle stall right after the first output.
    pops0 = pops;
    fork
      begin
        send(16'sd100, 16'sd100, 1'b0, 1'b0);
        send(16'sd1000, 16'sd1000, 1'b0, 1'b0);
        send(-16'sd1000, 16'sd1048, 1'b0, 1'b0);
        send(16'sd500, 16'sd500, 1'b0, 1'b0);
        send(-16'sd200, -16'sd200, 1'b0, 1'b0);
        idle();
      end
      begin
        wait_n = 0;
        while (!out_valid && wait_n < 50) begin
          @(negedge clk);
          wait_n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_output_count", pops - pops0, 5);
    restart();

    // Saturation / wrap ramp.
    ramp(34);
    drain();
    check("ramp_sat_sticky", 32'(sat_sticky), 32'(SAT_EN));

    // Clear mid-stream: in-flight samples and the sample offered with clear are dropped.
    send(16'sd0, 16'sd0, 1'b0, 1'b0);
    send(16'sd900, 16'sd900, 1'b0, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd500;
    @(negedge clk);
    check("clear_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("clear_out_valid", 32'(out_valid), 0);
    check("clear_sat_sticky", 32'(sat_sticky), 0);
    @(posedge clk);
    #1;
    send(-16'sd900, -16'sd900, 1'b0, 1'b1);
    send(16'sd900, -16'sd1148, 1'b0, 1'b1);
    idle();
    drain();
    restart();

    // Asynchronous reset mid-stream, between clock edges.
    ramp(36);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("areset_out_valid", 32'(out_valid), 0);
    check("areset_out_data", $signed(out_data), 0);
    check("areset_out_sat", 32'(out_sat), 0);
    check("areset_sat_sticky", 32'(sat_sticky), 0);
    check("areset_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Out-of-range first sample distinguishes FIRST (unfolded) from a RUN fold.
    send(16'sd1500, 16'sd1500, 1'b0, 1'b1);
    send(16'sd1500, 16'sd1500, 1'b0, 1'b1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_unfold.md
# modulo_unfold

Reconstruction-path stage that unwraps modulo-folded fixed-point samples before they are converted to IEEE-754 float. It implements first-order difference unfolding: form the sample-to-sample difference, fold it back into [-LAMBDA, LAMBDA), and accumulate. Input comes from the modulo-ADC sample interface. The output is a signed fixed-point stream in the same Q format, fed directly to the fixed-to-float converter.

## Interface
Parameters:
- TOTAL_BITS, 16: width of input and output samples (signed, two's complement).
- FRACTIONAL_BITS, 10: fractional bits of the Q format. Informational only; the arithmetic is format-agnostic.
- LAMBDA, 1024: modulo threshold in LSBs (1024 = 1.0 in Q5.10). Legal range 1 .. 2^(TOTAL_BITS-2).
- ACC_BITS, 24: internal accumulator width. Must be greater than TOTAL_BITS.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous frame restart, one-cycle pulse.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: stage can accept an input sample.
- in_data, input, TOTAL_BITS: folded sample y[n], expected range [-LAMBDA, LAMBDA).
- out_valid, output, 1: output sample valid.
- out_ready, input, 1: downstream accepts the output sample.
- out_data, output, TOTAL_BITS: unfolded sample x[n].
- out_sat, output, 1: out_data was clamped for this sample.
- sat_sticky, output, 1: at least one sample has saturated since the last reset or clear.

## Operation
- States:
  - FIRST: no sample taken since reset or clear.
  - RUN: at least one sample taken.
  - FIRST -> RUN on the first accepted input. RUN -> FIRST on clear.
- Stage 1 (difference), on each accepted sample:
  - Sign-extend in_data to TOTAL_BITS+2 bits and compute d = y[n] - prev.
  - In FIRST: d = y[n], with no fold.
  - In RUN, fold d:
    - if d >= LAMBDA: d = d - 2*LAMBDA
    - else if d < -LAMBDA: d = d + 2*LAMBDA
    - else d is unchanged.
  - Set prev <= y[n], then register d.
- Stage 2 (accumulate): acc <= acc + sign-extended d, using ACC_BITS two's-complement arithmetic (wraps at ACC_BITS).
- Output conversion from acc to TOTAL_BITS is described under Configuration.
- Out-of-range input (|y| >= LAMBDA) is not checked. It goes through the same arithmetic unchanged.
- clear:
  - Sets acc = 0, prev = 0, state = FIRST, sat_sticky = 0.
  - Drops both pipeline valids; in-flight samples are discarded.
  - clear overrides a simultaneous input handshake: in_ready is forced low while clear is high.
- Reset: same effect as clear. All outputs read 0: in_ready=0 during reset, out_valid=0, out_data=0, out_sat=0, sat_sticky=0.

## Timing
- Two-stage pipeline with a global enable: en = !out_valid || out_ready.
- in_ready = en && !clear.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: a sample accepted at rising edge N is presented on out_data with out_valid=1 after edge N+2.
- Throughput: one sample per cycle when out_ready is held high.
- While out_valid && !out_ready, all of these hold stable and in_ready stays 0:
  - out_data, out_sat
  - the stage-1 register
  - acc, prev, state
- A bubble (in_valid=0) propagates as an invalid slot. acc and prev do not change for that slot.
- out_valid is not cleared while out_ready is low, except by clear or reset.

## Configuration
- Macro: UNFOLD_SAT_EN.
- Defined:
  - If acc > 2^(TOTAL_BITS-1)-1, out_data is clamped to that maximum.
  - If acc < -2^(TOTAL_BITS-1), out_data is clamped to that minimum.
  - Otherwise out_data = acc.
  - out_sat = 1 for each clamped sample. sat_sticky sets on any clamped sample.
  - acc itself is never clamped, so later samples can return into range.
- Undefined:
  - out_data = acc[TOTAL_BITS-1:0], i.e. two's-complement wrap.
  - out_sat and sat_sticky are tied to 0.

## Test plan
- Basic unfold (LAMBDA=1024, out_ready=1): inputs 0, 900, -900, -700 -> out_data 0, 900, 1148, 1348, each appearing 2 cycles after its input.
- Negative fold: inputs 0, -900, 900 -> out_data 0, -900, -1148.
- Saturation (UNFOLD_SAT_EN defined): feed y[n] = ((1000*n + 1024) mod 2048) - 1024 for n = 0..34.
  - out_data tracks 1000*n through 32000.
  - n = 33 and 34 give 32767 with out_sat=1.
  - sat_sticky=1.
  - Without the macro, n = 33 gives -32536.
- Backpressure: stream 5 samples, holding out_ready=0 for 4 cycles after the first output.
  - out_data holds stable and in_ready=0 during the hold.
  - There is no loss or duplication; the final sequence equals the unstalled result.
- clear mid-stream: after inputs 0, 900, assert clear together with in_valid (sample 500).
  - in_ready=0, so sample 500 is not accepted.
  - out_valid=0 next cycle.
  - The next input -900 yields out_data -900 (FIRST state, no fold); sat_sticky=0.
- Asynchronous reset: assert rst_n=0 mid-stream, between clock edges.
  - out_valid, out_data, out_sat and sat_sticky go to 0 immediately.
  - After release, the first input is taken unfolded.
